// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: NBYTES-wide add through one 8-bit adder, LSB byte first.
// Optional MPADD_SUB_EN: sub on the accepted start turns the operation into a - b.
module mp_add_seq #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned CW     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    input  logic                  ci,
    input  logic                  sub,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  co,
    output logic                  ovf
);

    localparam int unsigned W = 8 * NBYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   a_sh, a_sh_n;
    logic [W-1:0]   b_sh, b_sh_n;
    logic           carry, carry_n;
    logic [CW-1:0]  idx, idx_n;
    logic [W-1:0]   sum_n;
    logic           co_n, ovf_n;
    logic           ready_n, busy_n, done_n;
    logic [8:0]     byte_s;

`ifndef MPADD_SUB_EN
    logic unused_sub;
    assign unused_sub = sub;
`endif

    // Shared byte adder always works on the low byte of the operand shift registers.
    assign byte_s = 9'(a_sh[7:0]) + 9'(b_sh[7:0]) + 9'(carry);

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_n = state;
        a_sh_n  = a_sh;
        b_sh_n  = b_sh;
        carry_n = carry;
        idx_n   = idx;
        sum_n   = sum;
        co_n    = co;
        ovf_n   = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    a_sh_n  = a_in;
                    b_sh_n  = b_in;
                    carry_n = ci;
`ifdef MPADD_SUB_EN
                    if (sub) begin
                        b_sh_n  = ~b_in;
                        carry_n = 1'b1;
                    end
`endif
                    idx_n   = '0;
                    sum_n   = '0;
                    co_n    = 1'b0;
                    ovf_n   = 1'b0;
                end
            end
            RUN: begin
                for (int k = 0; k < int'(NBYTES); k++) begin
                    if (idx == CW'(k)) begin
                        sum_n[8*k +: 8] = byte_s[7:0];
                    end
                end
                carry_n = byte_s[8];
                a_sh_n  = a_sh >> 8;
                b_sh_n  = b_sh >> 8;
                idx_n   = idx + CW'(1);
                if (idx == CW'(NBYTES - 1)) begin
                    co_n    = byte_s[8];
                    // carry into bit 7 of this byte is a7 ^ b7 ^ s7
                    ovf_n   = a_sh[7] ^ b_sh[7] ^ byte_s[7] ^ byte_s[8];
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n = (state_n == IDLE);
        busy_n  = (state_n == RUN);
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a_sh  <= a_sh_n;
            b_sh  <= b_sh_n;
            carry <= carry_n;
            idx   <= idx_n;
            sum   <= sum_n;
            co    <= co_n;
            ovf   <= ovf_n;
            ready <= ready_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (NBYTES=4): vector table, random ops vs. arithmetic model,
// and hand sequences for ignored start, held start and mid-operation reset.
module tb_mp_add_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 32;
`ifdef MPADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, ci, sub;
    logic [W-1:0] a_in, b_in, sum;
    logic         ready, busy, done, co, ovf;

    int n_checks = 0;
    int n_pass   = 0;

    mp_add_seq #(.NBYTES(NB), .CW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .ci    (ci),
        .sub   (sub),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         sb;
        logic [W-1:0] s;
        logic         co;
        logic         v;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: whole-word arithmetic, subtraction as a + ~b + 1.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic sb,
                                  output logic [W-1:0] s, output logic c_o, output logic v_o);
        logic [W-1:0] bb;
        logic         cc;
        logic [63:0]  t;
        bb = b;
        cc = c;
        if (SUB_EN && sb) begin
            bb = ~b;
            cc = 1'b1;
        end
        t   = 64'(a) + 64'(bb) + 64'(cc);
        s   = t[W-1:0];
        c_o = t[W];
        v_o = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Issue one start from IDLE and wait (bounded) for done; edges counts E0 as 1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic sb, output int edges, output int bcnt);
        @(negedge clk);
        a_in = a; b_in = b; ci = c; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = $urandom; b_in = $urandom; ci = 1'($urandom); sub = 1'($urandom);
        edges = 1;
        bcnt  = 0;
        while (!done && edges < 50) begin
            if (busy) bcnt++;
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        int edges, bcnt, cnt, first, second;
        logic [W-1:0] es, cap;
        logic ec, ev;

        tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
`ifdef MPADD_SUB_EN
        tbl[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
`else
        tbl[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0};
`endif
        tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; ci = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {61'd0, ready, busy, done}, 64'b100);
        check("reset_res", {30'd0, co, ovf, sum}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sb, edges, bcnt);
            check($sformatf("vec%0d_latency", i), 64'(edges), 64'(NB + 1));
            check($sformatf("vec%0d_busy", i), 64'(bcnt), 64'(NB));
            check($sformatf("vec%0d_sum", i), 64'(sum), 64'(tbl[i].s));
            check($sformatf("vec%0d_co_ovf", i), {62'd0, co, ovf}, {62'd0, tbl[i].co, tbl[i].v});
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), {62'd0, done, ready}, 64'b01);
        end

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            if (i % 5 == 0) ra = 32'hFFFFFFFF;
            model(ra, rb, rc, rs, es, ec, ev);
            run_op(ra, rb, rc, rs, edges, bcnt);
            check($sformatf("rand%0d_latency", i), 64'(edges), 64'(NB + 1));
            check($sformatf("rand%0d_result", i), {30'd0, co, ovf, sum}, {30'd0, ec, ev, es});
        end

        // Start pulsed during RUN must be ignored.
        model(32'h01020304, 32'h10203040, 1'b0, 1'b0, es, ec, ev);
        @(negedge clk);
        a_in = 32'h01020304; b_in = 32'h10203040; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 32'hDEADBEEF; b_in = 32'h0BADF00D; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; cap = '0;
        for (int k = 0; k < 14; k++) begin
            if (done) begin cnt++; cap = sum; end
            @(negedge clk);
        end
        check("ignored_start_dones", 64'(cnt), 64'd1);
        check("ignored_start_sum", 64'(cap), 64'(es));
        check("ignored_start_idle", {62'd0, ready, busy}, 64'b10);

        // Start held high: back-to-back operations.
        model(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, es, ec, ev);
        a_in = 32'h0000FFFF; b_in = 32'h00000001; ci = 1'b0; sub = 1'b0; start = 1'b1;
        first = -1; second = -1; cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
                check($sformatf("held_sum%0d", cnt), 64'(sum), 64'(es));
            end
        end
        start = 1'b0;
        check("held_dones", 64'(cnt), 64'd3);
        check("held_gap", 64'(second - first), 64'(NB + 2));
        cnt = 0;
        while (!ready && cnt < 20) begin @(negedge clk); cnt++; end
        check("held_drain", 64'(ready), 64'd1);

        // Reset during the second RUN cycle abandons the operation.
        @(negedge clk);
        a_in = 32'h11223344; b_in = 32'h01010101; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_ctrl", {61'd0, ready, busy, done}, 64'b100);
        check("midreset_res", {31'd0, co, sum}, 64'd0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) cnt++;
            @(negedge clk);
        end
        check("midreset_no_done", 64'(cnt), 64'd0);
        run_op(32'h00000010, 32'h00000020, 1'b0, 1'b0, edges, bcnt);
        check("post_reset_sum", {31'd0, co, sum}, 64'h30);
        check("post_reset_latency", 64'(edges), 64'(NB + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add sequencer around a single shared 8-bit add datapath (A, B, carry-in → S, carry-out).
- Performs an NBYTES-wide add one byte per clock, LSB byte first, chaining the carry between cycles.
- Sits between a control FSM or host and the 8-bit adder, trading latency for adder area.
- Start/busy/done handshake; results held until the next accepted start.

Parameters:
- NBYTES, 4, operand width in bytes (legal 1..16); total width W = 8*NBYTES.
- CW, 5, byte-index counter width; must satisfy 2^CW > NBYTES.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a_in  input  W  operand A, sampled on the accepted start.
- b_in  input  W  operand B, sampled on the accepted start.
- ci  input  1  initial carry-in, sampled on the accepted start.
- sub  input  1  subtract request; only meaningful with MPADD_SUB_EN.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse when the result is complete.
- sum  output  W  result; valid from the done cycle until the next accepted start.
- co  output  1  carry-out of the MSB byte.
- ovf  output  1  signed overflow: carry into bit W-1 XOR co.

Behaviour:
- Reset (synchronous): state=IDLE, idx=0, sum=0, co=0, ovf=0, done=0, busy=0, ready=1.
  - Applies mid-operation: the RUN sequence is abandoned, nothing completes, no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1 at edge E0:
  - Latch a_in and b_in into shift registers; carry register = ci; idx=0; go to RUN.
  - sum, co and ovf are cleared at E0.
- RUN, one edge per byte:
  - s = a[8*idx+:8] + b[8*idx+:8] + carry, computed as 9 bits.
  - sum byte idx = s[7:0]; carry = s[8]; idx++.
  - On the byte with idx==NBYTES-1: co = s[8]; ovf = carry into bit 7 of that byte XOR s[8]; go to DONE.
- DONE: done=1 for exactly one cycle, ready=0, then IDLE on the next edge.
- Latency: start accepted at E0, byte k written at edge E(k+1), done high during the cycle after edge E(NBYTES). Next start is accepted at the earliest in the cycle after done.
- start while RUN or DONE is ignored and not queued. start held high in IDLE re-triggers each time IDLE is reached.
- Operand inputs are don't-care except on the accepted start edge.
- NBYTES=1: exactly one RUN cycle, with the same done timing rule.
- Carry wraps out of the MSB into co only; the sum wraps modulo 2^W.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MPADD_SUB_EN.
- Defined:
  - sub is sampled on the accepted start.
  - If sub=1, the latched B is ~b_in and the initial carry is forced to 1 (ci ignored), giving sum = a−b mod 2^W.
  - co=1 means no borrow; ovf is signed subtraction overflow.
- Undefined: the sub port exists but is ignored; the block is add-only.

Test Plan:
- NBYTES=4, a=0x000000FF, b=0x00000001, ci=0 → sum=0x00000100, co=0, ovf=0. done asserts exactly 5 clocks after the start edge; busy high for 4 cycles.
- a=0xFFFFFFFF, b=0x00000000, ci=1 → sum=0x00000000, co=1, ovf=0. Checks carry ripple across all bytes.
- a=0x7FFFFFFF, b=0x00000001, ci=0 → sum=0x80000000, co=0, ovf=1.
- Second start pulsed during RUN → ignored: only one done pulse, result matches the first operands. Then start held high → back-to-back operations, each separated by the DONE cycle.
- reset asserted at the 2nd RUN cycle → next edge gives ready=1, sum=0, co=0, no done pulse. A subsequent 0x00000010+0x00000020 gives 0x00000030.
- With MPADD_SUB_EN: a=0x00000005, b=0x00000007, sub=1 → sum=0xFFFFFFFE, co=0. Without the macro, the same stimulus gives sum=0x0000000C.
